// File: rtl/demux_dff_4b.sv
// demux_dff_4b: steers one WIDTH-bit word into bank 0 or bank 1 on a
// synchronised, edge-detected load strobe. Bank choice is either the
// explicit select (manual) or an alternating pointer (ping-pong).
// Optional feature macro: DEMUX_CLR_EN (adds synchronous clear input clr).
module demux_dff_4b #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DEMUX_CLR_EN
  input  logic             clr,
`endif
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             ld,
  input  logic             auto,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic             v0,
  output logic             v1,
  output logic             ptr,
  output logic             last_sel,
  output logic [CNT_W-1:0] wr_cnt
);

  // Load synchroniser and edge-detect history
  logic sync1_q, sync2_q, prev_q;
  logic ld_pulse_s;
  logic clr_s;
  logic tgt_s;

  // Bank state and next-state
  logic [WIDTH-1:0] q0_q, q0_d, q1_q, q1_d;
  logic             v0_q, v0_d, v1_q, v1_d;
  logic             ptr_q, ptr_d;
  logic             last_sel_q, last_sel_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  assign ld_pulse_s = sync2_q & ~prev_q;

`ifdef DEMUX_CLR_EN
  assign clr_s = clr;
`else
  assign clr_s = 1'b0;
`endif

  // Two-flop synchroniser for the raw load level plus one-cycle history for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= ld;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next-state: clear beats a coincident write; a write updates only the targeted bank
  always_comb begin
    q0_d       = q0_q;
    q1_d       = q1_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    ptr_d      = ptr_q;
    last_sel_d = last_sel_q;
    wr_cnt_d   = wr_cnt_q;
    if (auto) begin
      tgt_s = ptr_q;
    end else begin
      tgt_s = s;
    end
    if (clr_s) begin
      // Counter deliberately survives a clear; the dropped write is not counted
      q0_d       = {WIDTH{1'b0}};
      q1_d       = {WIDTH{1'b0}};
      v0_d       = 1'b0;
      v1_d       = 1'b0;
      ptr_d      = 1'b0;
      last_sel_d = 1'b0;
    end else if (ld_pulse_s) begin
      if (tgt_s) begin
        q1_d = d;
        v1_d = 1'b1;
      end else begin
        q0_d = d;
        v0_d = 1'b1;
      end
      last_sel_d = tgt_s;
      wr_cnt_d   = wr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (auto) begin
        ptr_d = ~ptr_q;
      end else begin
        ptr_d = ptr_q;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State register for banks, flags, pointer and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0_q       <= {WIDTH{1'b0}};
      q1_q       <= {WIDTH{1'b0}};
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      ptr_q      <= 1'b0;
      last_sel_q <= 1'b0;
      wr_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      q0_q       <= q0_d;
      q1_q       <= q1_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      ptr_q      <= ptr_d;
      last_sel_q <= last_sel_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign q0       = q0_q;
  assign q1       = q1_q;
  assign v0       = v0_q;
  assign v1       = v1_q;
  assign ptr      = ptr_q;
  assign last_sel = last_sel_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_demux_dff_4b.sv
// Scoreboard bench for demux_dff_4b: each load stimulus pushes the expected
// post-write state and write edge; a monitor pops and compares whenever the
// write counter moves.
module tb_demux_dff_4b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d = 4'h0;
  logic       s = 1'b0;
  logic       ld = 1'b0;
  logic       auto = 1'b0;
`ifdef DEMUX_CLR_EN
  logic       clr = 1'b0;
`endif
  logic [3:0] q0, q1, wr_cnt;
  logic       v0, v1, ptr, last_sel;

  demux_dff_4b #(.WIDTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
`ifdef DEMUX_CLR_EN
    .clr(clr),
`endif
    .d(d), .s(s), .ld(ld), .auto(auto),
    .q0(q0), .q1(q1), .v0(v0), .v1(v1), .ptr(ptr),
    .last_sel(last_sel), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] q0, q1, cnt;
    logic       v0, v1, ptr, last_sel;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // reference state
  logic [3:0] m_q0 = 4'h0, m_q1 = 4'h0, m_cnt = 4'h0;
  logic       m_v0 = 1'b0, m_v1 = 1'b0, m_ptr = 1'b0, m_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q0 = 4'h0; m_q1 = 4'h0; m_v0 = 1'b0; m_v1 = 1'b0;
    m_ptr = 1'b0; m_last = 1'b0;
  endtask

  // one load press: level high for len cycles, then released
  task automatic pulse(input logic [3:0] dv, input logic sv, input logic av, input int len);
    exp_t e;
    logic tgt;
    @(negedge clk);
    d = dv; s = sv; auto = av; ld = 1'b1;
    tgt = av ? m_ptr : sv;
    if (tgt) begin m_q1 = dv; m_v1 = 1'b1; end
    else     begin m_q0 = dv; m_v0 = 1'b1; end
    m_last = tgt;
    m_cnt  = m_cnt + 4'd1;
    if (av) m_ptr = ~m_ptr;
    e.q0 = m_q0; e.q1 = m_q1; e.cnt = m_cnt; e.v0 = m_v0; e.v1 = m_v1;
    e.ptr = m_ptr; e.last_sel = m_last;
    e.cyc = cyc + 3;
    sb.push_back(e);
    repeat (len) @(negedge clk);
    ld = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // bounded wait for the scoreboard to empty
  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending"}, sb.size(), 0);
  endtask

  task automatic do_reset();
    drain("pre_reset");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_q0", q0, 4'h0);
    chk("rst_q1", q1, 4'h0);
    chk("rst_v", {v0, v1}, 2'b00);
    chk("rst_ptr_last", {ptr, last_sel}, 2'b00);
    chk("rst_cnt", wr_cnt, 4'h0);
    model_clear();
    m_cnt = 4'h0;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic chk_state(input string name, input logic [3:0] eq0, input logic [3:0] eq1,
                           input logic ev0, input logic ev1, input logic eptr,
                           input logic elast, input logic [3:0] ecnt);
    chk({name, "_q0"}, q0, eq0);
    chk({name, "_q1"}, q1, eq1);
    chk({name, "_v"}, {v0, v1}, {ev0, ev1});
    chk({name, "_ptr"}, ptr, eptr);
    chk({name, "_last"}, last_sel, elast);
    chk({name, "_cnt"}, wr_cnt, ecnt);
  endtask

  // monitor: a moving write counter marks a write; compare against the oldest expectation
  logic [3:0] seen_cnt = 4'h0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen_cnt = wr_cnt;
      end else if (wr_cnt !== seen_cnt) begin
        seen_cnt = wr_cnt;
        if (sb.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_q0", q0, e.q0);
          chk("wr_q1", q1, e.q1);
          chk("wr_v", {v0, v1}, {e.v0, e.v1});
          chk("wr_ptr", ptr, e.ptr);
          chk("wr_last", last_sel, e.last_sel);
          chk("wr_cnt", wr_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk_state("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    #1 rst = 1'b0;

    // manual write to bank 1, single-cycle ld
    pulse(4'hA, 1'b1, 1'b0, 1);
    drain("manual");
    chk_state("manual", 4'h0, 4'hA, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1);

    // ld held 20 cycles: exactly one write
    pulse(4'h5, 1'b0, 1'b0, 20);
    drain("hold");
    chk_state("hold", 4'h5, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2);

    // asynchronous reset with banks loaded
    do_reset();

    // ping-pong four writes
    pulse(4'h1, 1'b1, 1'b1, 1);
    pulse(4'h2, 1'b1, 1'b1, 2);
    pulse(4'h3, 1'b0, 1'b1, 1);
    pulse(4'h4, 1'b0, 1'b1, 3);
    drain("pingpong");
    chk_state("pingpong", 4'h3, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 4'h4);

    // mode switch keeps ptr: auto write -> bank0 (ptr=1), manual s=0 -> bank0, auto -> bank1
    pulse(4'h7, 1'b1, 1'b1, 1);
    pulse(4'h8, 1'b0, 1'b0, 1);
    chk("switch_ptr_held", ptr, 1'b1);
    pulse(4'h9, 1'b0, 1'b1, 1);
    drain("switch");
    chk_state("switch", 4'h8, 4'h9, 1'b1, 1'b1, 1'b0, 1'b1, 4'h7);

    // counter wrap: 17 writes from zero
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      pulse(4'(i + 2), 1'b0, 1'b1, 1);
    end
    drain("wrap");
    chk_state("wrap", 4'h3, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 4'h1);

`ifdef DEMUX_CLR_EN
    // clear coincident with the load pulse: write dropped, counter kept
    @(negedge clk);
    d = 4'hF; s = 1'b0; auto = 1'b0; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk_state("clr", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
    pulse(4'h6, 1'b1, 1'b0, 1);
    drain("after_clr");
    chk_state("after_clr", 4'h0, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 4'h2);
`endif

    repeat (5) @(negedge clk);
    chk("final_queue_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
